feature_window_loader: RTL

FEATURE_WINDOW_LOADER -- requirements
Module: feature_window_loader

---
 rtl/feature_pkg.sv | 13 +
 rtl/feature_window_loader.sv | 100 ++++++++++
 2 files changed

// File: rtl/feature_pkg.sv
// Shared definitions for the feature window loader: data width, window size and state type.
package feature_pkg;

    localparam int XLEN           = 32;
    localparam int NSLOT          = 41;
    localparam int FIRST_SLOT_DEF = 2;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/feature_window_loader.sv
// Purpose: collects NFEAT streamed samples into xarray[FIRST_SLOT..NSLOT-1] and presents the window.
// Latency: win_valid rises on the edge of the final accept; one sample per cycle while filling.
// Backpressure: in_ready low while a window is held, until win_ack. Macro FRAME_CHECK_EN enables in_last framing checks.
module feature_window_loader
    import feature_pkg::*;
#(
    parameter int NFEAT      = 39,
    parameter int FIRST_SLOT = FIRST_SLOT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [XLEN-1:0] xarray [0:NSLOT-1],
    output logic            win_valid,
    input  logic            win_ack,
    output logic            err
);

    localparam int CW = $clog2(NFEAT);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] win [FIRST_SLOT:NSLOT-1];
    logic            accept;
    logic            last_beat;
    logic            frame_abort;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CW'(NFEAT - 1));

`ifdef FRAME_CHECK_EN
    // An early in_last drops the partial window; a missing one only flags.
    assign frame_abort = accept && in_last && !last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && (in_last != last_beat)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign frame_abort    = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            win_valid <= 1'b0;
            for (int i = FIRST_SLOT; i < NSLOT; i++) begin
                win[i] <= '0;
            end
        end else begin
            for (int i = FIRST_SLOT; i < NSLOT; i++) begin
                if (accept && (cnt == CW'(i - FIRST_SLOT))) begin
                    win[i] <= in_data;
                end
            end
            case (state)
                FILL: begin
                    if (accept) begin
                        if (last_beat) begin
                            state     <= HOLD;
                            win_valid <= 1'b1;
                            cnt       <= '0;
                        end else if (frame_abort) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (win_ack) begin
                        state     <= FILL;
                        win_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Leading slots are constant zero padding for the inner-product stage.
    for (genvar g = 0; g < NSLOT; g++) begin : g_out
        if (g < FIRST_SLOT) begin : g_zero
            assign xarray[g] = '0;
        end else begin : g_win
            assign xarray[g] = win[g];
        end
    end

endmodule
